alu_rs: RTL and testbench

- Reservation station and issue scheduler for the integer ALU in the out-of-order RISC-V core.
- Buffers dispatched ALU/branch/jump µops and snoops both CDB broadcasts (ALU, LSB) to wake waiting operands.
- Each cycle issues at most one ready µop, via registered outputs, into the combinational ALU.
- Cleared on ROB flush (mispredict).

---
 rtl/alu_rs_pkg.sv | 51 +++++
 rtl/alu_rs_picker.sv | 48 ++++
 rtl/alu_rs.sv | 150 +++++++++++++++
 tb/tb_alu_rs.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_rs_pkg.sv
// Shared definitions for the ALU reservation station: geometry, reserved
// opcode/tag encodings, entry layout and the CDB snoop helper.
package alu_rs_pkg;

  localparam int RS_SIZE = 16;
  localparam int OP_W    = 6;
  localparam int TAG_W   = 4;
  localparam int DATA_W  = 32;
  localparam int IDX_W   = $clog2(RS_SIZE);
  localparam int AGE_W   = 4;

  localparam logic [OP_W-1:0]  OP_NOP   = '0;
  localparam logic [TAG_W-1:0] TAG_NONE = '0;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [TAG_W-1:0]  q1;
    logic [TAG_W-1:0]  q2;
    logic [DATA_W-1:0] v1;
    logic [DATA_W-1:0] v2;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc;
    logic [TAG_W-1:0]  rob_tag;
  } rs_entry_t;

  typedef struct packed {
    logic [TAG_W-1:0]  q;
    logic [DATA_W-1:0] v;
  } operand_t;

  // Resolve one operand against both CDBs; the ALU bus wins if both match.
  function automatic operand_t snoop(input operand_t          opnd,
                                     input logic [TAG_W-1:0]  alu_tag,
                                     input logic [DATA_W-1:0] alu_val,
                                     input logic [TAG_W-1:0]  lsb_tag,
                                     input logic [DATA_W-1:0] lsb_val);
    operand_t r;
    r = opnd;
    if (opnd.q != TAG_NONE) begin
      if (opnd.q == alu_tag) begin
        r.q = TAG_NONE;
        r.v = alu_val;
      end else if (opnd.q == lsb_tag) begin
        r.q = TAG_NONE;
        r.v = lsb_val;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_rs_picker.sv
// Combinational priority select over a request vector. Returns the lowest
// requesting index, or with ALU_RS_AGE_SELECT_EN defined the requester with
// the largest age (ties to the lowest index). Used for issue and allocation.
module alu_rs_picker
  import alu_rs_pkg::*;
#(
  parameter int N = RS_SIZE,
  parameter int W = IDX_W
) (
  input  logic [N-1:0]            req,
`ifdef ALU_RS_AGE_SELECT_EN
  input  logic [N-1:0][AGE_W-1:0] age,
`endif
  output logic [W-1:0]            idx,
  output logic                    found
);

`ifdef ALU_RS_AGE_SELECT_EN
  logic [AGE_W-1:0] best_age;

  // Oldest requester wins; strict compare keeps the lowest index on ties.
  always_comb begin
    found    = 1'b0;
    idx      = '0;
    best_age = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i] && (!found || age[i] > best_age)) begin
        found    = 1'b1;
        idx      = W'(i);
        best_age = age[i];
      end
    end
  end
`else
  // Lowest requesting index wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i] && !found) begin
        found = 1'b1;
        idx   = W'(i);
      end
    end
  end
`endif

endmodule

// File: rtl/alu_rs.sv
// Reservation station for the integer ALU. Buffers dispatched uops, wakes
// operands from the ALU and LSB CDBs and issues one ready uop per cycle on
// registered outputs. Optional macro ALU_RS_AGE_SELECT_EN switches issue to
// oldest-ready-first using per-entry saturating age counters.
module alu_rs
  import alu_rs_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              in_valid,
  input  logic [OP_W-1:0]   in_op,
  input  logic [TAG_W-1:0]  in_q1,
  input  logic [TAG_W-1:0]  in_q2,
  input  logic [DATA_W-1:0] in_v1,
  input  logic [DATA_W-1:0] in_v2,
  input  logic [DATA_W-1:0] in_imm,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [TAG_W-1:0]  in_rob_tag,
  input  logic [TAG_W-1:0]  in_alu_cdb_tag,
  input  logic [DATA_W-1:0] in_alu_cdb_value,
  input  logic [TAG_W-1:0]  in_lsb_cdb_tag,
  input  logic [DATA_W-1:0] in_lsb_cdb_value,
  input  logic              in_rob_clear,
  output logic              out_full,
  output logic [OP_W-1:0]   out_op,
  output logic [DATA_W-1:0] out_value1,
  output logic [DATA_W-1:0] out_value2,
  output logic [DATA_W-1:0] out_imm,
  output logic [DATA_W-1:0] out_pc,
  output logic [TAG_W-1:0]  out_rob_tag
);

  logic [RS_SIZE-1:0] busy;
  rs_entry_t          ent [RS_SIZE];
  logic [RS_SIZE-1:0] ready;
  operand_t           wk1 [RS_SIZE];
  operand_t           wk2 [RS_SIZE];
  operand_t           d1, d2;
  logic [IDX_W-1:0]   issue_idx, alloc_idx;
  logic               issue_found, free_found;

`ifdef ALU_RS_AGE_SELECT_EN
  logic [RS_SIZE-1:0][AGE_W-1:0] age;
`endif

  // Readiness from registered state only: a wakeup this cycle issues next cycle.
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      ready[i] = busy[i] && (ent[i].q1 == TAG_NONE) && (ent[i].q2 == TAG_NONE);
      wk1[i]   = snoop(operand_t'({ent[i].q1, ent[i].v1}), in_alu_cdb_tag,
                       in_alu_cdb_value, in_lsb_cdb_tag, in_lsb_cdb_value);
      wk2[i]   = snoop(operand_t'({ent[i].q2, ent[i].v2}), in_alu_cdb_tag,
                       in_alu_cdb_value, in_lsb_cdb_tag, in_lsb_cdb_value);
    end
  end

  // Same-cycle forwarding for the incoming uop.
  assign d1 = snoop(operand_t'({in_q1, in_v1}), in_alu_cdb_tag, in_alu_cdb_value,
                    in_lsb_cdb_tag, in_lsb_cdb_value);
  assign d2 = snoop(operand_t'({in_q2, in_v2}), in_alu_cdb_tag, in_alu_cdb_value,
                    in_lsb_cdb_tag, in_lsb_cdb_value);

  alu_rs_picker #(.N(RS_SIZE), .W(IDX_W)) u_issue_pick (
    .req   (ready),
`ifdef ALU_RS_AGE_SELECT_EN
    .age   (age),
`endif
    .idx   (issue_idx),
    .found (issue_found)
  );

  // Zero ages reduce the age-aware picker to lowest-free-index allocation.
  alu_rs_picker #(.N(RS_SIZE), .W(IDX_W)) u_alloc_pick (
    .req   (~busy),
`ifdef ALU_RS_AGE_SELECT_EN
    .age   ('0),
`endif
    .idx   (alloc_idx),
    .found (free_found)
  );

  // Full is taken from registered busy bits, so an issue frees a slot next cycle.
  assign out_full = ~free_found;

  // Entry storage, wakeup, issue and dispatch; flush overrides both.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy        <= '0;
      out_op      <= OP_NOP;
      out_value1  <= '0;
      out_value2  <= '0;
      out_imm     <= '0;
      out_pc      <= '0;
      out_rob_tag <= TAG_NONE;
`ifdef ALU_RS_AGE_SELECT_EN
      age         <= '0;
`endif
    end else if (rdy) begin
      if (in_rob_clear) begin
        busy        <= '0;
        out_op      <= OP_NOP;
        out_value1  <= '0;
        out_value2  <= '0;
        out_imm     <= '0;
        out_pc      <= '0;
        out_rob_tag <= TAG_NONE;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (busy[i]) begin
            ent[i].q1 <= wk1[i].q;
            ent[i].v1 <= wk1[i].v;
            ent[i].q2 <= wk2[i].q;
            ent[i].v2 <= wk2[i].v;
`ifdef ALU_RS_AGE_SELECT_EN
            if (age[i] != {AGE_W{1'b1}}) age[i] <= age[i] + AGE_W'(1);
`endif
          end
        end

        if (issue_found) begin
          out_op          <= ent[issue_idx].op;
          out_value1      <= ent[issue_idx].v1;
          out_value2      <= ent[issue_idx].v2;
          out_imm         <= ent[issue_idx].imm;
          out_pc          <= ent[issue_idx].pc;
          out_rob_tag     <= ent[issue_idx].rob_tag;
          busy[issue_idx] <= 1'b0;
        end else begin
          out_op      <= OP_NOP;
          out_value1  <= '0;
          out_value2  <= '0;
          out_imm     <= '0;
          out_pc      <= '0;
          out_rob_tag <= TAG_NONE;
        end

        if (in_valid && free_found) begin
          busy[alloc_idx] <= 1'b1;
          ent[alloc_idx]  <= '{op: in_op, q1: d1.q, q2: d2.q, v1: d1.v, v2: d2.v,
                               imm: in_imm, pc: in_pc, rob_tag: in_rob_tag};
`ifdef ALU_RS_AGE_SELECT_EN
          age[alloc_idx]  <= '0;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_rs.sv
// Directed bench for alu_rs: reset, issue latency, wakeup, forwarding,
// full/drop, flush, stall freeze and issue priority.
module tb_alu_rs;
  import alu_rs_pkg::*;

  localparam logic [OP_W-1:0] OP_ADDI = 6'd1;
  localparam logic [OP_W-1:0] OP_ADD  = 6'd2;

`ifdef ALU_RS_AGE_SELECT_EN
  localparam logic [OP_W-1:0]  FIRST_OP  = 6'd5;
  localparam logic [TAG_W-1:0] FIRST_TAG = 4'd13;
  localparam logic [OP_W-1:0]  SECOND_OP = 6'd4;
  localparam logic [TAG_W-1:0] SECOND_TAG = 4'd12;
`else
  localparam logic [OP_W-1:0]  FIRST_OP  = 6'd4;
  localparam logic [TAG_W-1:0] FIRST_TAG = 4'd12;
  localparam logic [OP_W-1:0]  SECOND_OP = 6'd5;
  localparam logic [TAG_W-1:0] SECOND_TAG = 4'd13;
`endif

  logic              clk = 1'b0;
  logic              rst, rdy, in_valid, in_rob_clear;
  logic [OP_W-1:0]   in_op;
  logic [TAG_W-1:0]  in_q1, in_q2, in_rob_tag, in_alu_cdb_tag, in_lsb_cdb_tag;
  logic [DATA_W-1:0] in_v1, in_v2, in_imm, in_pc, in_alu_cdb_value, in_lsb_cdb_value;
  logic              out_full;
  logic [OP_W-1:0]   out_op;
  logic [DATA_W-1:0] out_value1, out_value2, out_imm, out_pc;
  logic [TAG_W-1:0]  out_rob_tag;

  int n_checks = 0;
  int n_errors = 0;

  alu_rs dut (
    .clk(clk), .rst(rst), .rdy(rdy), .in_valid(in_valid), .in_op(in_op),
    .in_q1(in_q1), .in_q2(in_q2), .in_v1(in_v1), .in_v2(in_v2),
    .in_imm(in_imm), .in_pc(in_pc), .in_rob_tag(in_rob_tag),
    .in_alu_cdb_tag(in_alu_cdb_tag), .in_alu_cdb_value(in_alu_cdb_value),
    .in_lsb_cdb_tag(in_lsb_cdb_tag), .in_lsb_cdb_value(in_lsb_cdb_value),
    .in_rob_clear(in_rob_clear), .out_full(out_full), .out_op(out_op),
    .out_value1(out_value1), .out_value2(out_value2), .out_imm(out_imm),
    .out_pc(out_pc), .out_rob_tag(out_rob_tag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_cdb();
    in_alu_cdb_tag = '0; in_alu_cdb_value = '0;
    in_lsb_cdb_tag = '0; in_lsb_cdb_value = '0;
  endtask

  task automatic disp(input logic [OP_W-1:0] op, input logic [TAG_W-1:0] q1,
                      input logic [DATA_W-1:0] v1, input logic [TAG_W-1:0] q2,
                      input logic [DATA_W-1:0] v2, input logic [DATA_W-1:0] imm,
                      input logic [TAG_W-1:0] tag);
    in_valid = 1'b1; in_op = op; in_q1 = q1; in_v1 = v1; in_q2 = q2; in_v2 = v2;
    in_imm = imm; in_pc = 32'h1000 | {28'h0, tag}; in_rob_tag = tag;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic expect_idle(input string tag);
    check({tag, ".op"},  64'(out_op), 64'(OP_NOP));
    check({tag, ".tag"}, 64'(out_rob_tag), 64'(TAG_NONE));
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; in_valid = 1'b0; in_rob_clear = 1'b0;
    in_op = '0; in_q1 = '0; in_q2 = '0; in_v1 = '0; in_v2 = '0;
    in_imm = '0; in_pc = '0; in_rob_tag = '0;
    clear_cdb();

    // Reset then idle
    tick(); tick();
    rst = 1'b0;
    expect_idle("reset");
    check("reset.full", 64'(out_full), 64'd0);
    check("reset.v1", 64'(out_value1), 64'd0);

    // Ready dispatch: one-cycle issue latency
    disp(OP_ADDI, 4'd0, 32'd5, 4'd0, 32'd0, 32'd7, 4'd3);
    expect_idle("addi.lat");
    tick();
    check("addi.op",  64'(out_op), 64'(OP_ADDI));
    check("addi.v1",  64'(out_value1), 64'd5);
    check("addi.imm", 64'(out_imm), 64'd7);
    check("addi.pc",  64'(out_pc), 64'h1003);
    check("addi.tag", 64'(out_rob_tag), 64'd3);
    tick();
    expect_idle("addi.after");

    // Wakeup from LSB CDB
    disp(OP_ADD, 4'd4, 32'd0, 4'd0, 32'd2, 32'd0, 4'd5);
    tick();
    expect_idle("wake.wait1");
    tick();
    expect_idle("wake.wait2");
    in_lsb_cdb_tag = 4'd4; in_lsb_cdb_value = 32'h10;
    tick();
    clear_cdb();
    expect_idle("wake.bcast");
    tick();
    check("wake.op",  64'(out_op), 64'(OP_ADD));
    check("wake.v1",  64'(out_value1), 64'h10);
    check("wake.v2",  64'(out_value2), 64'd2);
    check("wake.tag", 64'(out_rob_tag), 64'd5);
    tick();
    expect_idle("wake.after");

    // Same-cycle forwarding from ALU CDB
    in_alu_cdb_tag = 4'd6; in_alu_cdb_value = 32'd9;
    disp(OP_ADD, 4'd0, 32'd1, 4'd6, 32'd0, 32'd0, 4'd8);
    clear_cdb();
    expect_idle("fwd.lat");
    tick();
    check("fwd.op",  64'(out_op), 64'(OP_ADD));
    check("fwd.v2",  64'(out_value2), 64'd9);
    check("fwd.tag", 64'(out_rob_tag), 64'd8);

    // Fill all 16 entries, drop a 17th, then flush
    for (int i = 0; i < RS_SIZE; i++) begin
      disp(OP_ADD, 4'd7, 32'd0, 4'd0, 32'd0, 32'd0, TAG_W'(i % 15 + 1));
      if (i == RS_SIZE - 2) check("full.15", 64'(out_full), 64'd0);
    end
    check("full.16", 64'(out_full), 64'd1);
    disp(6'd3, 4'd0, 32'd1, 4'd0, 32'd1, 32'd0, 4'd9);
    check("full.still", 64'(out_full), 64'd1);
    tick();
    expect_idle("full.drop");
    in_rob_clear = 1'b1;
    tick();
    in_rob_clear = 1'b0;
    check("flush.full", 64'(out_full), 64'd0);
    expect_idle("flush");
    in_alu_cdb_tag = 4'd7; in_alu_cdb_value = 32'd1;
    tick();
    clear_cdb();
    tick();
    expect_idle("flush.bc1");
    tick();
    expect_idle("flush.bc2");

    // Priority and stall: slots 0..5, slot 2 recycled after issuing
    disp(OP_ADD, 4'd10, 32'd0, 4'd0, 32'd0, 32'd0, 4'd2);
    disp(OP_ADD, 4'd10, 32'd0, 4'd0, 32'd0, 32'd0, 4'd3);
    disp(6'd6,   4'd12, 32'd0, 4'd0, 32'd0, 32'd0, 4'd1);
    disp(OP_ADD, 4'd10, 32'd0, 4'd0, 32'd0, 32'd0, 4'd4);
    disp(OP_ADD, 4'd10, 32'd0, 4'd0, 32'd0, 32'd0, 4'd5);
    disp(6'd5,   4'd11, 32'd0, 4'd0, 32'd0, 32'd0, 4'd13);
    in_alu_cdb_tag = 4'd12; in_alu_cdb_value = 32'd0;
    tick();
    clear_cdb();
    expect_idle("prio.w12");
    tick();
    check("prio.s2.op",  64'(out_op), 64'd6);
    check("prio.s2.tag", 64'(out_rob_tag), 64'd1);
    disp(6'd4, 4'd11, 32'd0, 4'd0, 32'd0, 32'd0, 4'd12);
    check("prio.full", 64'(out_full), 64'd0);
    in_lsb_cdb_tag = 4'd11; in_lsb_cdb_value = 32'h55;
    tick();
    clear_cdb();
    expect_idle("prio.w11");
    tick();
    check("prio.first.op",  64'(out_op), 64'(FIRST_OP));
    check("prio.first.tag", 64'(out_rob_tag), 64'(FIRST_TAG));
    check("prio.first.v1",  64'(out_value1), 64'h55);

    rdy = 1'b0;
    in_alu_cdb_tag = 4'd10; in_alu_cdb_value = 32'h77;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall.op",  64'(out_op), 64'(FIRST_OP));
      check("stall.tag", 64'(out_rob_tag), 64'(FIRST_TAG));
    end
    rdy = 1'b1;
    clear_cdb();
    tick();
    check("prio.second.op",  64'(out_op), 64'(SECOND_OP));
    check("prio.second.tag", 64'(out_rob_tag), 64'(SECOND_TAG));
    tick();
    expect_idle("stall.cdb_ignored");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
